// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath: operand width, exponentiation
// controller state encoding and its bit-counter width.
package rsa_pkg;

  localparam int RSA_WIDTH = 256;
  localparam int CNT_W     = $clog2(RSA_WIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    REDUCE,
    SCAN,
    SQR,
    MUL,
    FINISH,
    DONE
  } state_t;

endpackage

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for base^exp mod modulus,
// driving an external modular multiplier over a ready/valid handshake.
module mod_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] mm_y,
  output logic [WIDTH-1:0] mm_z,
  output logic [WIDTH-1:0] mm_n,
  output logic             mm_ready,
  input  logic [WIDTH-1:0] mm_M,
  input  logic             mm_valid,
  output state_t           dbg_state
);

  // Multiplier handshake: mm_ready is a one-cycle launch pulse with the
  // operands registered alongside it; mm_valid is a one-cycle pulse carrying
  // mm_M. Only one product is ever outstanding, and mm_valid is honoured only
  // while this block is waiting on a product it launched.

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state;
  logic             issued;
  logic [WIDTH-1:0] base_r;
  logic [WIDTH-1:0] exp_r;
  logic [WIDTH-1:0] mod_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      issued   <= 1'b0;
      base_r   <= '0;
      exp_r    <= '0;
      mod_r    <= '0;
      b_r      <= '0;
      acc      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      result   <= '0;
      mm_y     <= '0;
      mm_z     <= '0;
      mm_n     <= '0;
      mm_ready <= 1'b0;
    end else begin
      mm_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_r <= base;
            exp_r  <= exp;
            mod_r  <= modulus;
            busy   <= 1'b1;
            state  <= CHECK;
          end
        end
        CHECK: begin
          issued <= 1'b0;
          if (mod_r == '0) begin
            result <= '0;
            err    <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else if (mod_r == WIDTH'(1)) begin
            result <= '0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else if (exp_r == '0) begin
            result <= WIDTH'(1);
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else begin
            state <= REDUCE;
          end
        end
        REDUCE: begin
          // base * 1 mod n brings a base >= modulus into range
          if (!issued) begin
            mm_y     <= base_r;
            mm_z     <= WIDTH'(1);
            mm_n     <= mod_r;
            mm_ready <= 1'b1;
            issued   <= 1'b1;
          end else if (mm_valid) begin
            b_r    <= mm_M;
            acc    <= mm_M;
            cnt    <= CW'(WIDTH - 1);
            issued <= 1'b0;
            state  <= SCAN;
          end
        end
        SCAN: begin
          // cnt tracks the bit position now at the MSB; at the leading one it
          // equals the number of exponent bits still to process
          exp_r <= exp_r << 1;
          if (exp_r[WIDTH-1]) state <= (cnt == '0) ? FINISH : SQR;
          else                cnt   <= cnt - 1'b1;
        end
        SQR: begin
          if (!issued) begin
            mm_y     <= acc;
            mm_z     <= acc;
            mm_n     <= mod_r;
            mm_ready <= 1'b1;
            issued   <= 1'b1;
          end else if (mm_valid) begin
            acc    <= mm_M;
            issued <= 1'b0;
            if (exp_r[WIDTH-1]) begin
              state <= MUL;
            end else begin
              exp_r <= exp_r << 1;
              cnt   <= cnt - 1'b1;
              state <= (cnt == CW'(1)) ? FINISH : SQR;
            end
          end
        end
        MUL: begin
          if (!issued) begin
            mm_y     <= acc;
            mm_z     <= b_r;
            mm_n     <= mod_r;
            mm_ready <= 1'b1;
            issued   <= 1'b1;
          end else if (mm_valid) begin
            acc    <= mm_M;
            issued <= 1'b0;
            exp_r  <= exp_r << 1;
            cnt    <= cnt - 1'b1;
            state  <= (cnt == CW'(1)) ? FINISH : SQR;
          end
        end
        FINISH: begin
          result <= acc;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Self-checking bench for mod_exp_ctrl with a behavioural modular multiplier
// of random latency and a plain-arithmetic modexp reference.
module tb_mod_exp_ctrl;
  import rsa_pkg::*;

  localparam int W      = 256;
  localparam int BUDGET = 6000;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [W-1:0] base;
  logic [W-1:0] exp;
  logic [W-1:0] modulus;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] result;
  logic [W-1:0] mm_y;
  logic [W-1:0] mm_z;
  logic [W-1:0] mm_n;
  logic         mm_ready;
  logic [W-1:0] mm_M = '0;
  logic         mm_valid = 1'b0;
  state_t       dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  logic [W-1:0] exp_q[$];

  mod_exp_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .base     (base),
    .exp      (exp),
    .modulus  (modulus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result),
    .mm_y     (mm_y),
    .mm_z     (mm_z),
    .mm_n     (mm_n),
    .mm_ready (mm_ready),
    .mm_M     (mm_M),
    .mm_valid (mm_valid),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] n);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    p = p % {{W{1'b0}}, n};
    return p[W-1:0];
  endfunction

  // right-to-left exponentiation: a different walk than the controller's
  function automatic logic [W-1:0] ref_exp(input logic [W-1:0] b, input logic [W-1:0] e,
                                           input logic [W-1:0] n);
    logic [W-1:0] r;
    logic [W-1:0] x;
    if (n <= 1) return '0;
    r = 1;
    x = mulmod(b, 1, n);
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = mulmod(r, x, n);
      x = mulmod(x, x, n);
    end
    return r;
  endfunction

  function automatic int ref_mults(input logic [W-1:0] e, input logic [W-1:0] n);
    int len;
    if (n <= 1 || e == 0) return 0;
    len = 0;
    for (int i = 0; i < W; i++) if (e[i]) len = i + 1;
    return len + $countones(e) - 1;
  endfunction

  // behavioural mul_mod: random latency, counts launches and overlap errors
  int           ready_cnt = 0;
  int           proto_err = 0;
  int           lat_cnt   = 0;
  bit           pending   = 1'b0;
  logic [W-1:0] prod      = '0;

  always @(negedge clk) begin
    mm_valid = 1'b0;
    if (lat_cnt != 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        mm_valid = 1'b1;
        mm_M     = prod;
        pending  = 1'b0;
      end
    end
    if (mm_ready === 1'b1) begin
      ready_cnt++;
      if (pending) proto_err++;
      pending = 1'b1;
      prod    = mulmod(mm_y, mm_z, mm_n);
      lat_cnt = $urandom_range(1, 6);
    end
  end

  // mode 0: plain, 1: spurious start during SQR, 2: reset during a MUL wait
  task automatic run_op(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] n,
                        input int mode);
    logic [W-1:0] want;
    int  want_mults;
    int  r0;
    int  p0;
    int  cyc;
    bit  shortcut;
    bit  injected;
    exp_q.push_back(ref_exp(b, e, n));
    want_mults = ref_mults(e, n);
    shortcut   = (n <= 1) || (e == 0);
    r0 = ready_cnt;
    p0 = proto_err;
    injected = 1'b0;
    @(negedge clk);
    base = b; exp = e; modulus = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("busy_rise", busy, 1);
    check("err_low_busy", err, 0);
    while (cyc < BUDGET) begin
      if (done) break;
      if (mode == 2 && dbg_state == MUL && !mm_ready) begin
        reset_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_mm_ready", mm_ready, 0);
        check("rst_result", result, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        void'(exp_q.pop_front());
        repeat (12) @(negedge clk);
        check("rst_idle_after_stray_valid", busy, 0);
        return;
      end
      if (mode == 1 && !injected && dbg_state == SQR) begin
        base = ~b; exp = e ^ 3; modulus = n + 2; start = 1'b1;
        injected = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    if (mode == 2) check("rst_mul_reached", 0, 1);
    if (mode == 1) check("inject_hit", injected, 1);
    check("done_seen", done, 1);
    if (done) begin
      want = exp_q.pop_front();
      check("result", result, want);
      check("err", err, (n == 0) ? 1 : 0);
      check("busy_at_done", busy, 0);
      check("mults", ready_cnt - r0, want_mults);
      check("handshake_overlap", proto_err - p0, 0);
      if (shortcut) check("shortcut_latency", cyc, 2);
      @(negedge clk);
      check("done_pulse", done, 0);
      check("err_clear", err, 0);
      check("result_hold", result, want);
    end else begin
      void'(exp_q.pop_front());
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [W-1:0] t;
    logic [W-1:0] m;
    reset_n = 1'b0; start = 1'b0; base = '0; exp = '0; modulus = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_mm_ready", mm_ready, 0);
    check("reset_result", result, 0);
    check("reset_mm_y", mm_y, 0);
    check("reset_mm_z", mm_z, 0);
    check("reset_mm_n", mm_n, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(4, 13, 497, 0);
    check("known_445", result, 445);
    run_op(10, 1, 7, 0);
    check("known_reduce", result, 3);
    run_op(3, 0, 7, 0);
    run_op(5, 9, 1, 0);
    run_op(5, 9, 0, 0);

    t = '0; t[W-1] = 1'b1; t[0] = 1'b1;
    m = '0; m[W-1] = 1'b1; m = m + 19;
    run_op(2, t, m, 0);

    run_op(7, 45, 1009, 1);
    run_op(4, 13, 497, 0);
    run_op(4, 13, 497, 2);
    run_op(4, 13, 497, 0);
    check("after_reset_445", result, 445);

    for (int k = 0; k < 8; k++) begin
      t = rand_wide();
      m = rand_wide();
      if (k[0]) m = {{(W-16){1'b0}}, m[15:0]};
      run_op(rand_wide(), {{(W-12){1'b0}}, t[11:0]}, m, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
